// File: rtl/disp_pkg.sv
// Shared constants, state type and the hex segment table for the display scan driver.
package disp_pkg;
    localparam int N_DIGITS = 4;
    localparam logic [6:0]          SEG_OFF = 7'h7F;
    localparam logic [N_DIGITS-1:0] AN_OFF  = 4'hF;

    typedef enum logic {DRIVE, GUARD} disp_state_t;

    // Active-low {g,f,e,d,c,b,a}, entry 15 first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    assign o_seg = SEG_TABLE[i_nib];
endmodule

// File: rtl/disp_scan.sv
// Four-digit seven-segment scan driver with per-digit guard blanking and frame latching.
// Optional leading-zero suppression when DISP_LZ_BLANK_EN is defined.
module disp_scan
    import disp_pkg::*;
#(
    parameter int BLANK_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_in,
    input  logic [15:0]         value,
    input  logic [N_DIGITS-1:0] dp_in,
    input  logic                blank_in,
    output logic [N_DIGITS-1:0] an,
    output logic [6:0]          seg,
    output logic                dp,
    output logic                frame_done
);
    localparam logic [7:0] GLOAD = 8'(BLANK_CYCLES - 1);

    disp_state_t         r_state;
    logic [1:0]          r_idx;
    logic [7:0]          r_gcnt;
    logic                r_tick_q;
    logic [15:0]         r_val_latch;
    logic [N_DIGITS-1:0] r_dp_latch;
    logic [N_DIGITS-1:0] r_an;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic                r_frame_done;

    logic       w_step;
    logic       w_wrap;
    logic       w_dark;
    logic [3:0] w_nib;
    logic [6:0] w_dec;
    logic [6:0] w_seg;

    // Rising edges seen during GUARD are dropped, not queued.
    assign w_step = tick_in & ~r_tick_q & (r_state == DRIVE);
    assign w_wrap = w_step & (r_idx == 2'd3);
    assign w_dark = blank_in | w_step | ((r_state == GUARD) && (r_gcnt != 8'd0));
    assign w_nib  = r_val_latch[{r_idx, 2'b00} +: 4];

    hex7seg u_dec (
        .i_nib (w_nib),
        .o_seg (w_dec)
    );

`ifdef DISP_LZ_BLANK_EN
    logic w_lz;
    always_comb begin
        w_lz = 1'b0;
        case (r_idx)
            2'd3:    w_lz = (r_val_latch[15:12] == 4'h0);
            2'd2:    w_lz = (r_val_latch[15:8] == 8'h0);
            2'd1:    w_lz = (r_val_latch[15:4] == 12'h0);
            default: w_lz = 1'b0;
        endcase
    end
    assign w_seg = w_lz ? SEG_OFF : w_dec;
`else
    assign w_seg = w_dec;
`endif

    // Output registers are loaded from the next-cycle view so they line up with the FSM state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= DRIVE;
            r_idx        <= 2'd0;
            r_gcnt       <= 8'd0;
            r_tick_q     <= 1'b0;
            r_val_latch  <= 16'h0000;
            r_dp_latch   <= '0;
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_tick_q     <= tick_in;
            r_frame_done <= w_wrap;
            case (r_state)
                DRIVE: begin
                    if (w_step) begin
                        r_state <= GUARD;
                        r_gcnt  <= GLOAD;
                        r_idx   <= r_idx + 2'd1;
                    end
                end
                GUARD: begin
                    if (r_gcnt == 8'd0) r_state <= DRIVE;
                    else                r_gcnt  <= r_gcnt - 8'd1;
                end
                default: r_state <= DRIVE;
            endcase
            if (w_wrap) begin
                r_val_latch <= value;
                r_dp_latch  <= dp_in;
            end
            if (w_dark) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_OFF;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= AN_OFF ^ (N_DIGITS'(1) << r_idx);
                r_seg <= w_seg;
                r_dp  <= ~r_dp_latch[r_idx];
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan: reset, frame scan, tearing, blanking, dropped/held edges, leading zeros.
module tb_disp_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_in = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_in = 1'b0;
    logic [3:0]  an, an8;
    logic [6:0]  seg, seg8;
    logic        dp, dp8, frame_done, fd8;

    int checks = 0;
    int errors = 0;

`ifdef DISP_LZ_BLANK_EN
    localparam logic [7:0] LZ_SEG = 8'h7F;
`else
    localparam logic [7:0] LZ_SEG = 8'h40;
`endif

    always #5 clk = ~clk;

    disp_scan #(.BLANK_CYCLES(4)) u_dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .value(value), .dp_in(dp_in),
        .blank_in(blank_in), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    disp_scan #(.BLANK_CYCLES(8)) u_dut8 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .value(value), .dp_in(dp_in),
        .blank_in(blank_in), .an(an8), .seg(seg8), .dp(dp8), .frame_done(fd8)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising tick edge, then the 4-cycle guard, then the driven digit.
    task automatic do_digit(input string tag, input logic [7:0] e_an, input logic [7:0] e_seg,
                            input logic [7:0] e_dp, input logic [7:0] e_fd);
        tick_in = 1'b1;
        cyc(1);
        chk({tag, " guard1 an"}, 8'(an), 8'hF);
        chk({tag, " frame_done"}, 8'(frame_done), e_fd);
        tick_in = 1'b0;
        cyc(3);
        chk({tag, " guard4 an"}, 8'(an), 8'hF);
        chk({tag, " fd low"}, 8'(frame_done), 8'h0);
        cyc(1);
        chk({tag, " an"}, 8'(an), e_an);
        chk({tag, " seg"}, 8'(seg), e_seg);
        chk({tag, " dp"}, 8'(dp), e_dp);
    endtask

    initial begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tick_in = ~tick_in;
            cyc(1);
            chk("rst an", 8'(an), 8'hF);
            chk("rst seg", 8'(seg), 8'h7F);
            chk("rst dp", 8'(dp), 8'h1);
            chk("rst fd", 8'(frame_done), 8'h0);
        end
        tick_in = 1'b0;
        rst = 1'b1;
        cyc(1);
        chk("post-rst an", 8'(an), 8'hE);
        chk("post-rst seg", 8'(seg), 8'h40);
        chk("post-rst dp", 8'(dp), 8'h1);

        value = 16'h1A3F;
        dp_in = 4'b0100;
        do_digit("ff t1", 8'hD, 8'h40, 8'h1, 8'h0);
        do_digit("ff t2", 8'hB, 8'h40, 8'h1, 8'h0);
        do_digit("ff t3", 8'h7, 8'h40, 8'h1, 8'h0);
        do_digit("ff t4", 8'hE, 8'h0E, 8'h1, 8'h1);
        do_digit("ff t5", 8'hD, 8'h30, 8'h1, 8'h0);
        do_digit("ff t6", 8'hB, 8'h08, 8'h0, 8'h0);
        do_digit("ff t7", 8'h7, 8'h79, 8'h1, 8'h0);
        do_digit("ff t8", 8'hE, 8'h0E, 8'h1, 8'h1);

        value = 16'h1234;
        dp_in = 4'b0000;
        do_digit("tear t1", 8'hD, 8'h30, 8'h1, 8'h0);
        do_digit("tear t2", 8'hB, 8'h08, 8'h0, 8'h0);
        do_digit("tear t3", 8'h7, 8'h79, 8'h1, 8'h0);
        do_digit("tear t4", 8'hE, 8'h19, 8'h1, 8'h1);
        do_digit("tear t5", 8'hD, 8'h30, 8'h1, 8'h0);
        do_digit("tear t6", 8'hB, 8'h24, 8'h1, 8'h0);
        value = 16'hABCD;
        do_digit("tear t7", 8'h7, 8'h79, 8'h1, 8'h0);
        do_digit("tear t8", 8'hE, 8'h21, 8'h1, 8'h1);
        do_digit("tear t9", 8'hD, 8'h46, 8'h1, 8'h0);

        blank_in = 1'b1;
        cyc(1);
        chk("blank on an", 8'(an), 8'hF);
        do_digit("blk t1", 8'hF, 8'h7F, 8'h1, 8'h0);
        do_digit("blk t2", 8'hF, 8'h7F, 8'h1, 8'h0);
        do_digit("blk t3", 8'hF, 8'h7F, 8'h1, 8'h1);
        do_digit("blk t4", 8'hF, 8'h7F, 8'h1, 8'h0);
        do_digit("blk t5", 8'hF, 8'h7F, 8'h1, 8'h0);
        do_digit("blk t6", 8'hF, 8'h7F, 8'h1, 8'h0);
        do_digit("blk t7", 8'hF, 8'h7F, 8'h1, 8'h1);
        do_digit("blk t8", 8'hF, 8'h7F, 8'h1, 8'h0);
        blank_in = 1'b0;
        cyc(1);
        chk("unblank an", 8'(an), 8'hD);
        chk("unblank seg", 8'(seg), 8'h46);

        value = 16'h0050;
        do_digit("lz t1", 8'hB, 8'h03, 8'h1, 8'h0);
        do_digit("lz t2", 8'h7, 8'h08, 8'h1, 8'h0);
        do_digit("lz t3", 8'hE, 8'h40, 8'h1, 8'h1);
        do_digit("lz t4", 8'hD, 8'h12, 8'h1, 8'h0);
        do_digit("lz t5", 8'hB, LZ_SEG, 8'h1, 8'h0);
        do_digit("lz t6", 8'h7, LZ_SEG, 8'h1, 8'h0);

        rst = 1'b0;
        #1;
        chk("midscan rst an", 8'(an), 8'hF);
        chk("midscan rst seg", 8'(seg), 8'h7F);
        chk("midscan rst dp", 8'(dp), 8'h1);
        @(negedge clk);
        rst = 1'b1;
        cyc(1);
        chk("rerst an", 8'(an), 8'hE);
        chk("rerst an8", 8'(an8), 8'hE);

        tick_in = 1'b1;
        cyc(1);
        chk("drop guard an8", 8'(an8), 8'hF);
        tick_in = 1'b0;
        cyc(2);
        tick_in = 1'b1;
        cyc(1);
        tick_in = 1'b0;
        cyc(4);
        chk("drop guard8 an8", 8'(an8), 8'hF);
        cyc(1);
        chk("drop once an8", 8'(an8), 8'hD);
        chk("drop once an4", 8'(an), 8'hD);
        cyc(3);
        chk("drop no queue an8", 8'(an8), 8'hD);

        tick_in = 1'b1;
        cyc(1);
        chk("hold guard an", 8'(an), 8'hF);
        cyc(4);
        chk("hold adv an", 8'(an), 8'hB);
        cyc(5);
        chk("hold single an", 8'(an), 8'hB);
        tick_in = 1'b0;
        cyc(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
